lock_sequencer: RTL and testbench
=================================

Name: lock_sequencer

Overview:
- Top-level sequencing FSM for the electronic lock.
- Collects keypad digits into a 4-digit buffer and drives the one-cycle confirm and change-password strobes of the password manager.
- Samples the manager's match and change-mode flags, then runs the unlocked window and the failed-attempt lockout.
- Sits between the debounced button/keypad front end and the password manager. Also drives the status LEDs.

Parameters:
- UNLOCK_CYCLES, 625_000_000, cycles the lock stays open after a correct code (5 s at 125 MHz).
- LOCKOUT_CYCLES, 3_750_000_000, cycles of lockout after MAX_FAILS consecutive failures (30 s).
- MAX_FAILS, 3, consecutive wrong codes that trigger lockout (1..7).
- TMR_W, 32, width of the shared timer counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digit_valid  in  1  one-cycle pulse: keypad digit present
- digit  in  4  BCD digit value; values >9 are ignored
- btn_enter  in  1  one-cycle pulse: submit buffer
- btn_clear  in  1  one-cycle pulse: clear buffer / relock
- btn_change  in  1  one-cycle pulse: request password change
- pm_match  in  1  match flag from password manager
- pm_change_mode  in  1  change-mode LED flag from password manager
- bcd0..bcd3  out  4 each  entry buffer to password manager (bcd3 = first digit entered)
- confirm_fullpass  out  1  registered one-cycle strobe
- change_pass  out  1  registered one-cycle strobe
- digit_count  out  3  digits buffered, 0..4
- unlocked  out  1  lock open
- alarm  out  1  lockout active
- change_active  out  1  in password-change entry
- fail_count  out  3  consecutive failures
- state_dbg  out  3  FSM state encoding

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0.
- States and transitions:
  - IDLE: digit entry. If pm_change_mode=1 in IDLE, go to CHG_ENTRY (resyncs after a reset mid-change).
  - VERIFY: confirm_fullpass=1 for this one cycle → EVAL.
  - EVAL: sample pm_match (it was registered by the manager on the VERIFY edge).
    - pm_match=1: fail_count←0, clear buffer, load timer ← UNLOCK_CYCLES-1, go to UNLOCKED.
    - pm_match=0: fail_count+1 and clear buffer. If the new fail_count equals MAX_FAILS, load timer ← LOCKOUT_CYCLES-1 and go to LOCKOUT; otherwise go to IDLE.
  - UNLOCKED: unlocked=1; timer decrements each cycle.
    - Timer==0 → IDLE. Otherwise btn_clear → IDLE. Otherwise btn_change → CHG_REQ.
  - CHG_REQ: change_pass=1 for one cycle → CHG_ACK.
  - CHG_ACK: pm_change_mode=1 → CHG_ENTRY with buffer cleared; otherwise → UNLOCKED (timer keeps running, not reloaded).
  - CHG_ENTRY: change_active=1; digit entry. Enter with 4 digits → COMMIT. No timeout and no abort, so the manager is never stranded in change mode.
  - COMMIT: confirm_fullpass=1 for one cycle; clear buffer → IDLE.
  - LOCKOUT: alarm=1; all buttons and digits ignored; timer decrements. At 0: fail_count←0 → IDLE.
- Digit entry (IDLE, CHG_ENTRY only):
  - Valid digit with count<4: shift bcd3←bcd2←bcd1←bcd0←digit, count+1.
  - Count==4 or digit>9: ignored.
- Priority in entry states: btn_enter > btn_clear > digit_valid.
- btn_enter with count<4: ignored; no strobe, no failure counted.
- btn_clear in an entry state: buffer and count ← 0.
- Buttons and digits arriving in VERIFY/EVAL/CHG_REQ/CHG_ACK/COMMIT are dropped.
- Timers: remaining count = param-1, so the dwell is exactly the parameter value in cycles, then one transition cycle. Buffer contents are held through VERIFY/COMMIT.
- Reset mid-operation returns to IDLE. The password manager is not reset; resync happens via the pm_change_mode rule in IDLE.

Decomposition:
- Package lock_pkg holds:
  - state enum: IDLE=0, VERIFY=1, EVAL=2, UNLOCKED=3, CHG_REQ=4, CHG_ACK=5, CHG_ENTRY=6, LOCKOUT=7.
  - default cycle constants.
  - digit-count width.
- Sub-module digit_entry_buffer: shift register plus 0..4 counter with load/clear/shift controls. FSM and timer stay in lock_sequencer.

Test Plan:
- Digits 1,1,1,1 + enter, model returns match=1 on the EVAL cycle → confirm_fullpass high exactly one cycle; unlocked=1 from EVAL+1; with UNLOCK_CYCLES=20, unlocked drops after 20 cycles.
- Three entries of 2,3,4,5 with match=0 → fail_count 1,2,3; third gives alarm=1. With LOCKOUT_CYCLES=50, digits during lockout are ignored; alarm clears after 50 cycles and fail_count=0.
- Unlocked, btn_change, model raises change_mode → change_pass one cycle, change_active=1. Enter 9,8,7,6 + enter → COMMIT strobe with bcd3..0=9,8,7,6, then IDLE.
- Enter with 3 digits → no strobe; fifth digit with count 4 is ignored. Same-cycle btn_enter + btn_clear with 4 digits → VERIFY taken.
- btn_change while unlocked, model keeps change_mode=0 → return to UNLOCKED; timer not reloaded.
- rst asserted in CHG_ENTRY while model change_mode stays 1 → after reset, IDLE for one cycle then CHG_ENTRY.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state encoding, default timing constants and entry-buffer types
// for the electronic lock sequencer.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VERIFY    = 3'd1,
    ST_EVAL      = 3'd2,
    ST_UNLOCKED  = 3'd3,
    ST_CHG_REQ   = 3'd4,
    ST_CHG_ACK   = 3'd5,
    ST_CHG_ENTRY = 3'd6,
    ST_LOCKOUT   = 3'd7
  } state_e;

  // Defaults assume a 125 MHz clock: 5 s open window, 30 s lockout.
  localparam int unsigned DEF_UNLOCK_CYCLES  = 32'd625_000_000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 32'd3_750_000_000;
  localparam int unsigned DEF_MAX_FAILS      = 32'd3;
  localparam int unsigned DEF_TMR_W          = 32'd32;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned FAIL_W  = 3;
  localparam int unsigned STATE_W = 3;

  // bcd3 holds the first digit entered, bcd0 the most recent.
  typedef struct packed {
    logic [BCD_W-1:0] d3;
    logic [BCD_W-1:0] d2;
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } bcd_buf_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_W'(9);
  endfunction

endpackage

// File: rtl/digit_entry_buffer.sv
// Four-digit BCD shift buffer with a 0..4 fill counter; drops non-BCD digits
// and digits arriving once the buffer is full.
module digit_entry_buffer
  import lock_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic [BCD_W-1:0] digit_i,
  output bcd_buf_t         buf_o,
  output logic [CNT_W-1:0] count_o
);

  bcd_buf_t         buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = shift_i && (cnt_q < CNT_W'(DIGITS)) && is_bcd(digit_i);

  // Clear wins over a shift presented in the same cycle.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      buf_d = {buf_q.d2, buf_q.d1, buf_q.d0, digit_i};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buf_o   = buf_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/lock_sequencer.sv
// Top-level lock FSM: keypad entry, verify/commit strobes to the password
// manager, unlocked window, password-change handshake and failure lockout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned TMR_W          = DEF_TMR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               digit_valid_i,
  input  logic [BCD_W-1:0]   digit_i,
  input  logic               btn_enter_i,
  input  logic               btn_clear_i,
  input  logic               btn_change_i,
  input  logic               pm_match_i,
  input  logic               pm_change_mode_i,
  output logic [BCD_W-1:0]   bcd0_o,
  output logic [BCD_W-1:0]   bcd1_o,
  output logic [BCD_W-1:0]   bcd2_o,
  output logic [BCD_W-1:0]   bcd3_o,
  output logic               confirm_fullpass_o,
  output logic               change_pass_o,
  output logic [CNT_W-1:0]   digit_count_o,
  output logic               unlocked_o,
  output logic               alarm_o,
  output logic               change_active_o,
  output logic [FAIL_W-1:0]  fail_count_o,
  output logic [STATE_W-1:0] state_dbg_o
);

  localparam logic [TMR_W-1:0]  UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAILS);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TMR_W-1:0]  timer_dec;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              commit_q, commit_d;
  logic              confirm_q, change_q, unlocked_q, alarm_q, active_q;

  logic              buf_clear, buf_shift, buf_full;
  bcd_buf_t          entry_buf;
  logic [CNT_W-1:0]  entry_cnt;

  digit_entry_buffer u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (buf_clear),
    .shift_i (buf_shift),
    .digit_i (digit_i),
    .buf_o   (entry_buf),
    .count_o (entry_cnt)
  );

  assign buf_full  = (entry_cnt == CNT_W'(DIGITS));
  assign timer_dec = (timer_q == '0) ? timer_q : timer_q - TMR_W'(1);

  // Next-state logic. The commit cycle reuses the VERIFY encoding; commit_q
  // tells it apart so it returns to IDLE instead of evaluating a match.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    fail_d    = fail_q;
    commit_d  = commit_q;
    buf_clear = 1'b0;
    buf_shift = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pm_change_mode_i) begin
          state_d = ST_CHG_ENTRY;
        end else if (btn_enter_i && buf_full) begin
          state_d  = ST_VERIFY;
          commit_d = 1'b0;
        end else if (btn_clear_i) begin
          buf_clear = 1'b1;
        end else if (digit_valid_i) begin
          buf_shift = 1'b1;
        end
      end
      ST_VERIFY: begin
        if (commit_q) begin
          state_d   = ST_IDLE;
          commit_d  = 1'b0;
          buf_clear = 1'b1;
        end else begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        buf_clear = 1'b1;
        if (pm_match_i) begin
          fail_d  = '0;
          timer_d = UNLOCK_LOAD;
          state_d = ST_UNLOCKED;
        end else begin
          fail_d = fail_q + FAIL_W'(1);
          if (fail_d == FAIL_LIMIT) begin
            timer_d = LOCKOUT_LOAD;
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_UNLOCKED: begin
        timer_d = timer_dec;
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else if (btn_clear_i) begin
          state_d = ST_IDLE;
        end else if (btn_change_i) begin
          state_d = ST_CHG_REQ;
        end
      end
      ST_CHG_REQ: begin
        timer_d = timer_dec;
        state_d = ST_CHG_ACK;
      end
      ST_CHG_ACK: begin
        // The open window keeps counting down while the manager answers.
        timer_d = timer_dec;
        if (pm_change_mode_i) begin
          state_d   = ST_CHG_ENTRY;
          buf_clear = 1'b1;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_CHG_ENTRY: begin
        if (btn_enter_i && buf_full) begin
          state_d  = ST_VERIFY;
          commit_d = 1'b1;
        end else if (btn_clear_i) begin
          buf_clear = 1'b1;
        end else if (digit_valid_i) begin
          buf_shift = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        timer_d = timer_dec;
        if (timer_q == '0) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timer and registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      fail_q     <= '0;
      commit_q   <= 1'b0;
      confirm_q  <= 1'b0;
      change_q   <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      commit_q   <= commit_d;
      confirm_q  <= (state_d == ST_VERIFY);
      change_q   <= (state_d == ST_CHG_REQ);
      unlocked_q <= (state_d == ST_UNLOCKED);
      alarm_q    <= (state_d == ST_LOCKOUT);
      active_q   <= (state_d == ST_CHG_ENTRY);
    end
  end

  assign bcd0_o             = entry_buf.d0;
  assign bcd1_o             = entry_buf.d1;
  assign bcd2_o             = entry_buf.d2;
  assign bcd3_o             = entry_buf.d3;
  assign digit_count_o      = entry_cnt;
  assign confirm_fullpass_o = confirm_q;
  assign change_pass_o      = change_q;
  assign unlocked_o         = unlocked_q;
  assign alarm_o            = alarm_q;
  assign change_active_o    = active_q;
  assign fail_count_o       = fail_q;
  assign state_dbg_o        = STATE_W'(state_q);

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer with a behavioural password manager
// and scenario-level expectations derived from the lock's rules.
module tb_lock_sequencer;

  localparam int unsigned T_UNLOCK  = 20;
  localparam int unsigned T_LOCKOUT = 50;
  localparam int unsigned T_FAILS   = 3;

  localparam logic [2:0] S_IDLE = 3'd0, S_VERIFY = 3'd1, S_EVAL = 3'd2,
                         S_UNLOCKED = 3'd3, S_CHG_REQ = 3'd4, S_CHG_ACK = 3'd5,
                         S_CHG_ENTRY = 3'd6, S_LOCKOUT = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       btn_enter = 1'b0, btn_clear = 1'b0, btn_change = 1'b0;
  logic       pm_match = 1'b0;
  logic       pm_change_mode = 1'b0;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       confirm, change_pass, unlocked, alarm, change_active;
  logic [2:0] digit_count, fail_count, state_dbg;
  logic [15:0] bcd_word;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Password manager model: first digit in the top nibble.
  logic [15:0] pw_word = 16'h1111;
  bit          refuse  = 1'b0;

  lock_sequencer #(
    .UNLOCK_CYCLES (T_UNLOCK),
    .LOCKOUT_CYCLES(T_LOCKOUT),
    .MAX_FAILS     (T_FAILS),
    .TMR_W         (32)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .digit_valid_i     (digit_valid),
    .digit_i           (digit),
    .btn_enter_i       (btn_enter),
    .btn_clear_i       (btn_clear),
    .btn_change_i      (btn_change),
    .pm_match_i        (pm_match),
    .pm_change_mode_i  (pm_change_mode),
    .bcd0_o            (bcd0),
    .bcd1_o            (bcd1),
    .bcd2_o            (bcd2),
    .bcd3_o            (bcd3),
    .confirm_fullpass_o(confirm),
    .change_pass_o     (change_pass),
    .digit_count_o     (digit_count),
    .unlocked_o        (unlocked),
    .alarm_o           (alarm),
    .change_active_o   (change_active),
    .fail_count_o      (fail_count),
    .state_dbg_o       (state_dbg)
  );

  assign bcd_word = {bcd3, bcd2, bcd1, bcd0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (change_pass && !refuse) pm_change_mode <= 1'b1;
    if (confirm) begin
      if (pm_change_mode) begin
        pw_word        <= bcd_word;
        pm_change_mode <= 1'b0;
      end else begin
        pm_match <= (bcd_word == pw_word);
      end
    end
  end

  function automatic logic [15:0] pack_q(input logic [3:0] q[$]);
    logic [15:0] r = '0;
    foreach (q[i]) r = {r[11:0], q[i]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter_btn();
    btn_enter = 1'b1; tick(); btn_enter = 1'b0;
  endtask

  task automatic clear_btn();
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
  endtask

  task automatic change_btn();
    btn_change = 1'b1; tick(); btn_change = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) key(code[i*4 +: 4]);
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] c = '0;
    for (int i = 0; i < 4; i++) c = {c[11:0], 4'($urandom_range(0, 9))};
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++;
    if ({bcd_word, confirm, change_pass, digit_count, unlocked, alarm, change_active,
         fail_count, state_dbg} !== 33'd0) begin
      bad++;
      $display("FAIL reset: outputs=%h want all zero", {bcd_word, confirm, change_pass,
               digit_count, unlocked, alarm, change_active, fail_count, state_dbg});
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_digit_entry();
    logic [3:0] q[$];
    logic [3:0] d;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        clear_btn();
        q.delete();
      end else begin
        d = 4'($urandom_range(0, 15));
        key(d);
        if (d <= 4'd9 && q.size() < 4) q.push_back(d);
      end
      total++;
      if (bcd_word !== pack_q(q) || digit_count !== 3'(q.size())) begin
        bad++;
        $display("FAIL entry[%0d]: buf=%h cnt=%0d want buf=%h cnt=%0d", i, bcd_word,
                 digit_count, pack_q(q), q.size());
      end
    end
    clear_btn();
    q.delete();
    for (int i = 0; i < 3; i++) key(4'(i + 5));
    enter_btn();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (confirm !== 1'b0 || state_dbg !== S_IDLE || fail_count !== 3'd0) begin
        bad++;
        $display("FAIL short_enter: confirm=%b state=%0d fails=%0d want 0/0/0",
                 confirm, state_dbg, fail_count);
      end
      tick();
    end
    key(4'd8);
    key(4'd2);
    total++;
    if (digit_count !== 3'd4 || bcd_word !== 16'h5678) begin
      bad++;
      $display("FAIL fifth_digit: buf=%h cnt=%0d want 5678/4", bcd_word, digit_count);
    end
    clear_btn();
  endtask

  task automatic test_unlock();
    int n;
    enter_code(pw_word);
    btn_enter = 1'b1; btn_clear = 1'b1;
    tick();
    btn_enter = 1'b0; btn_clear = 1'b0;
    total++;
    if (state_dbg !== S_VERIFY || confirm !== 1'b1 || bcd_word !== pw_word) begin
      bad++;
      $display("FAIL verify: state=%0d confirm=%b buf=%h want 1/1/%h", state_dbg, confirm,
               bcd_word, pw_word);
    end
    tick();
    total++;
    if (state_dbg !== S_EVAL || confirm !== 1'b0) begin
      bad++;
      $display("FAIL eval: state=%0d confirm=%b want 2/0", state_dbg, confirm);
    end
    tick();
    total++;
    if (unlocked !== 1'b1 || digit_count !== 3'd0 || fail_count !== 3'd0) begin
      bad++;
      $display("FAIL unlock: unlocked=%b cnt=%0d fails=%0d want 1/0/0", unlocked,
               digit_count, fail_count);
    end
    n = 0;
    while (unlocked === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n != T_UNLOCK || state_dbg !== S_IDLE) begin
      bad++;
      $display("FAIL unlock_window: cycles=%0d state=%0d want %0d/0", n, state_dbg, T_UNLOCK);
    end
  endtask

  task automatic test_fail_lockout();
    logic [15:0] code;
    int n;
    for (int k = 1; k <= int'(T_FAILS); k++) begin
      code = 16'h2345;
      if (k > 1) begin
        code = rand_code();
        while (code == pw_word) code = rand_code();
      end
      enter_code(code);
      enter_btn();
      tick();
      tick();
      total++;
      if (fail_count !== 3'(k) || alarm !== (k == int'(T_FAILS)) || digit_count !== 3'd0) begin
        bad++;
        $display("FAIL fail_%0d: fails=%0d alarm=%b cnt=%0d want %0d/%b/0", k, fail_count,
                 alarm, digit_count, k, k == int'(T_FAILS));
      end
    end
    n = 0;
    while (alarm === 1'b1 && n < 300) begin
      digit_valid = 1'($urandom_range(0, 1));
      digit       = 4'($urandom_range(0, 9));
      btn_enter   = 1'($urandom_range(0, 1));
      btn_clear   = 1'($urandom_range(0, 1));
      tick();
      n++;
      total++;
      if (digit_count !== 3'd0 || confirm !== 1'b0) begin
        bad++;
        $display("FAIL lockout_ignore: cnt=%0d confirm=%b want 0/0", digit_count, confirm);
      end
    end
    digit_valid = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    total++;
    if (n != T_LOCKOUT || fail_count !== 3'd0 || state_dbg !== S_IDLE) begin
      bad++;
      $display("FAIL lockout_end: cycles=%0d fails=%0d state=%0d want %0d/0/0", n, fail_count,
               state_dbg, T_LOCKOUT);
    end
  endtask

  task automatic test_change();
    logic [15:0] newc;
    newc = rand_code();
    while (newc == pw_word) newc = rand_code();
    enter_code(pw_word);
    enter_btn();
    tick();
    tick();
    change_btn();
    total++;
    if (state_dbg !== S_CHG_REQ || change_pass !== 1'b1 || unlocked !== 1'b0) begin
      bad++;
      $display("FAIL chg_req: state=%0d change_pass=%b unlocked=%b want 4/1/0", state_dbg,
               change_pass, unlocked);
    end
    tick();
    tick();
    total++;
    if (state_dbg !== S_CHG_ENTRY || change_active !== 1'b1 || change_pass !== 1'b0) begin
      bad++;
      $display("FAIL chg_entry: state=%0d active=%b change_pass=%b want 6/1/0", state_dbg,
               change_active, change_pass);
    end
    enter_code(newc);
    key(4'($urandom_range(0, 9)));
    enter_btn();
    total++;
    if (confirm !== 1'b1 || bcd_word !== newc || change_active !== 1'b0) begin
      bad++;
      $display("FAIL commit: confirm=%b buf=%h active=%b want 1/%h/0", confirm, bcd_word,
               change_active, newc);
    end
    tick();
    tick();
    total++;
    if (state_dbg !== S_IDLE || digit_count !== 3'd0 || confirm !== 1'b0) begin
      bad++;
      $display("FAIL commit_idle: state=%0d cnt=%0d confirm=%b want 0/0/0", state_dbg,
               digit_count, confirm);
    end
    enter_code(newc);
    enter_btn();
    tick();
    tick();
    total++;
    if (unlocked !== 1'b1) begin
      bad++;
      $display("FAIL new_code_unlock: unlocked=%b want 1", unlocked);
    end
    clear_btn();
    total++;
    if (unlocked !== 1'b0 || state_dbg !== S_IDLE) begin
      bad++;
      $display("FAIL relock: unlocked=%b state=%0d want 0/0", unlocked, state_dbg);
    end
  endtask

  task automatic test_change_reject();
    int rise;
    int n;
    refuse = 1'b1;
    enter_code(pw_word);
    enter_btn();
    tick();
    tick();
    rise = cyc;
    repeat ($urandom_range(1, 8)) tick();
    change_btn();
    tick();
    tick();
    total++;
    if (state_dbg !== S_UNLOCKED || unlocked !== 1'b1 || change_active !== 1'b0) begin
      bad++;
      $display("FAIL chg_reject: state=%0d unlocked=%b active=%b want 3/1/0", state_dbg,
               unlocked, change_active);
    end
    n = 0;
    while (state_dbg !== S_IDLE && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (cyc - rise != int'(T_UNLOCK)) begin
      bad++;
      $display("FAIL chg_reject_window: open=%0d want %0d", cyc - rise, T_UNLOCK);
    end
    refuse = 1'b0;
  endtask

  task automatic test_reset_resync();
    enter_code(pw_word);
    enter_btn();
    tick();
    tick();
    change_btn();
    tick();
    tick();
    key(4'd3);
    key(4'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (state_dbg !== S_IDLE || digit_count !== 3'd0 || change_active !== 1'b0) begin
      bad++;
      $display("FAIL resync_reset: state=%0d cnt=%0d active=%b want 0/0/0", state_dbg,
               digit_count, change_active);
    end
    tick();
    total++;
    if (state_dbg !== S_CHG_ENTRY || change_active !== 1'b1) begin
      bad++;
      $display("FAIL resync_entry: state=%0d active=%b want 6/1", state_dbg, change_active);
    end
    enter_code(16'h9876);
    enter_btn();
    tick();
    tick();
    total++;
    if (state_dbg !== S_IDLE || pw_word !== 16'h9876) begin
      bad++;
      $display("FAIL resync_commit: state=%0d pw=%h want 0/9876", state_dbg, pw_word);
    end
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_unlock();
    test_fail_lockout();
    test_change();
    test_change_reject();
    test_reset_resync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
